// File: rtl/avalon_reg_bridge_if.sv
// Avalon-MM slave-side signal bundle for avalon_reg_bridge.
// The master modport is the bus initiator; the slave modport is the bridge.
interface avalon_reg_bridge_if #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32
) ();
  logic [AddrWidth-3:0]  avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [BusWidth-1:0]   avs_writedata;
  logic [BusWidth/8-1:0] avs_byteenable;
  logic [BusWidth-1:0]   avs_readdata;
  logic                  avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avalon_reg_bridge.sv
// avalon_reg_bridge: Avalon-MM slave that turns each transfer into a one-cycle
// register-bus strobe, with a fixed read latency and a fixed post-write gap.
// Build macro AVS_BYTEENABLE_RMW_EN: a write with a partial byteenable becomes a
// read-modify-write. Without it, byteenable is ignored and all writes are full-word.
//
// state      | meaning
// IDLE       | waiting for a request; write wins when read and write are both high
// RD_STROBE  | chip_sel + read_reg for one cycle, latency counter loaded
// RD_WAIT    | count down; capture busdata_in when the counter reaches zero
// RD_DONE    | waitrequest low for one cycle, readdata valid
// RMW_MERGE  | (RMW build only) enabled lanes of writedata merged over captured word
// WR_STROBE  | chip_sel + write_reg for one cycle, gap counter loaded
// WR_GAP     | idle cycles after the write strobe
// WR_DONE    | waitrequest low for one cycle
module avalon_reg_bridge #(
  parameter int AddrWidth   = 16,
  parameter int BusWidth    = 32,
  parameter int ReadLatency = 4,
  parameter int WriteGap    = 3
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  avalon_reg_bridge_if.slave   avs,
  output logic                 chip_sel,
  output logic                 read_reg,
  output logic                 write_reg,
  output logic [AddrWidth-3:0] busaddress,
  output logic [BusWidth-1:0]  busdata_out,
  input  logic [BusWidth-1:0]  busdata_in
);

  localparam int Lanes    = BusWidth / 8;
  localparam int CntMax   = (ReadLatency > WriteGap) ? ReadLatency : WriteGap;
  localparam int CntWidth = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntWidth-1:0] RdLoad  = CntWidth'(ReadLatency - 1);
  localparam logic [CntWidth-1:0] GapLoad = CntWidth'((WriteGap > 0) ? WriteGap - 1 : 0);

`ifdef AVS_BYTEENABLE_RMW_EN
  typedef enum logic [2:0] {
    IDLE, RD_STROBE, RD_WAIT, RD_DONE, WR_STROBE, WR_GAP, WR_DONE, RMW_MERGE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_STROBE, RD_WAIT, RD_DONE, WR_STROBE, WR_GAP, WR_DONE
  } state_t;
`endif

  state_t              state;
  state_t              state_next;
  logic [CntWidth-1:0] cnt;
  logic                accept;

  assign accept = (state == IDLE) && (avs.avs_read || avs.avs_write);

`ifdef AVS_BYTEENABLE_RMW_EN
  logic             rmw_start;
  logic             rmw_q;
  logic [Lanes-1:0] be_q;
  assign rmw_start = avs.avs_write && (avs.avs_byteenable != '1);
`else
  logic unused_be;
  assign unused_be = ^avs.avs_byteenable;
`endif

  // State register
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state decode and state-decoded strobes / waitrequest
  always_comb begin
    state_next          = state;
    chip_sel            = 1'b0;
    read_reg            = 1'b0;
    write_reg           = 1'b0;
    avs.avs_waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (avs.avs_write) begin
`ifdef AVS_BYTEENABLE_RMW_EN
          state_next = rmw_start ? RD_STROBE : WR_STROBE;
`else
          state_next = WR_STROBE;
`endif
        end else if (avs.avs_read) begin
          state_next = RD_STROBE;
        end
      end
      RD_STROBE: begin
        chip_sel   = 1'b1;
        read_reg   = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt == '0) begin
`ifdef AVS_BYTEENABLE_RMW_EN
          state_next = rmw_q ? RMW_MERGE : RD_DONE;
`else
          state_next = RD_DONE;
`endif
        end
      end
      RD_DONE: begin
        avs.avs_waitrequest = 1'b0;
        state_next          = IDLE;
      end
`ifdef AVS_BYTEENABLE_RMW_EN
      RMW_MERGE: state_next = WR_STROBE;
`endif
      WR_STROBE: begin
        chip_sel   = 1'b1;
        write_reg  = 1'b1;
        state_next = (WriteGap == 0) ? WR_DONE : WR_GAP;
      end
      WR_GAP: begin
        if (cnt == '0) state_next = WR_DONE;
      end
      WR_DONE: begin
        avs.avs_waitrequest = 1'b0;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared latency / gap down-counter, loaded in the strobe cycles
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      cnt <= '0;
    end else if (state == RD_STROBE) begin
      cnt <= RdLoad;
    end else if (state == WR_STROBE) begin
      cnt <= GapLoad;
    end else if ((state == RD_WAIT || state == WR_GAP) && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Address/data capture on accept, read capture at terminal count, RMW merge
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      busaddress       <= '0;
      busdata_out      <= '0;
      avs.avs_readdata <= '0;
`ifdef AVS_BYTEENABLE_RMW_EN
      rmw_q            <= 1'b0;
      be_q             <= '0;
`endif
    end else begin
      if (accept) begin
        busaddress  <= avs.avs_address;
        busdata_out <= avs.avs_writedata;
`ifdef AVS_BYTEENABLE_RMW_EN
        rmw_q       <= rmw_start;
        be_q        <= avs.avs_byteenable;
`endif
      end
      if (state == RD_WAIT && cnt == '0) begin
        avs.avs_readdata <= busdata_in;
      end
`ifdef AVS_BYTEENABLE_RMW_EN
      // Disabled lanes take the captured word; enabled lanes keep writedata.
      if (state == RMW_MERGE) begin
        for (int i = 0; i < Lanes; i++) begin
          if (!be_q[i]) busdata_out[i*8 +: 8] <= avs.avs_readdata[i*8 +: 8];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_avalon_reg_bridge.sv
// Bench for avalon_reg_bridge: a transaction-level timing model predicts strobes,
// acknowledges, address/data hold and captured read data on every cycle; directed
// transfers add hand-computed latency and data checks.
module tb_avalon_reg_bridge;
  localparam int AW = 16;
  localparam int BW = 32;
  localparam int RL = 4;
  localparam int WG = 3;

  logic          reg_clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          chip_sel, read_reg, write_reg;
  logic [AW-3:0] busaddress;
  logic [BW-1:0] busdata_out, busdata_in;
  logic [BW-1:0] rd_base = '0;
  logic          vary = 1'b0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  avalon_reg_bridge_if #(.AddrWidth(AW), .BusWidth(BW)) bus ();

  avalon_reg_bridge #(
    .AddrWidth(AW), .BusWidth(BW), .ReadLatency(RL), .WriteGap(WG)
  ) dut (
    .reg_clk    (reg_clk),
    .reset_in   (reset_in),
    .avs        (bus),
    .chip_sel   (chip_sel),
    .read_reg   (read_reg),
    .write_reg  (write_reg),
    .busaddress (busaddress),
    .busdata_out(busdata_out),
    .busdata_in (busdata_in)
  );

  always #5 reg_clk = ~reg_clk;
  always @(posedge reg_clk) cyc <= cyc + 1;

  // Register decoder stand-in: constant word, or a word that changes every cycle
  // so that the capture cycle is observable.
  assign busdata_in = vary ? (rd_base ^ BW'(cyc)) : rd_base;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction model: per accepted transfer, the cycles of each event.
  bit            m_busy = 1'b0;
  int            m_rd_s, m_wr_s, m_cap, m_merge, m_ack;
  logic [AW-3:0] m_addr = '0;
  logic [BW-1:0] m_bdo = '0;
  logic [BW-1:0] m_rdata = '0;
  logic [BW/8-1:0] m_be = '0;
  bit            e_rd, e_wr, e_ack;

  // Observed events, used by the directed literal checks.
  int            obs_rd_last = -1, obs_rd_prev = -1, obs_wr_last = -1, obs_ack_last = -1;
  int            n_rd = 0, n_wr = 0, n_ack = 0;
  logic [BW-1:0] obs_wr_data = '0, obs_ack_data = '0;

  always @(negedge reg_clk) begin
    if (read_reg) begin obs_rd_prev = obs_rd_last; obs_rd_last = cyc; n_rd++; end
    if (write_reg) begin obs_wr_last = cyc; n_wr++; obs_wr_data = busdata_out; end
    if (!bus.avs_waitrequest) begin obs_ack_last = cyc; n_ack++; obs_ack_data = bus.avs_readdata; end

    if (reset_in) begin
      chk("rst_waitrequest", bus.avs_waitrequest, 1);
      chk("rst_strobes", {chip_sel, read_reg, write_reg}, 0);
      chk("rst_busaddress", busaddress, 0);
      chk("rst_busdata_out", busdata_out, 0);
      chk("rst_readdata", bus.avs_readdata, 0);
      m_busy = 1'b0; m_addr = '0; m_bdo = '0; m_rdata = '0;
    end else begin
      e_rd  = m_busy && (cyc == m_rd_s);
      e_wr  = m_busy && (cyc == m_wr_s);
      e_ack = m_busy && (cyc == m_ack);
      chk("read_reg", read_reg, e_rd);
      chk("write_reg", write_reg, e_wr);
      chk("chip_sel", chip_sel, e_rd | e_wr);
      chk("waitrequest", bus.avs_waitrequest, !e_ack);
      chk("busaddress", busaddress, m_addr);
      chk("busdata_out", busdata_out, m_bdo);
      chk("readdata", bus.avs_readdata, m_rdata);

      if (m_busy) begin
        if (cyc == m_cap) m_rdata = busdata_in;
`ifdef AVS_BYTEENABLE_RMW_EN
        if (cyc == m_merge)
          for (int i = 0; i < BW/8; i++)
            if (!m_be[i]) m_bdo[i*8 +: 8] = m_rdata[i*8 +: 8];
`endif
        if (e_ack) m_busy = 1'b0;
      end else if (bus.avs_write || bus.avs_read) begin
        m_busy = 1'b1;
        m_addr = bus.avs_address;
        m_bdo  = bus.avs_writedata;
        m_be   = bus.avs_byteenable;
        m_rd_s = -1; m_wr_s = -1; m_cap = -1; m_merge = -1;
        if (bus.avs_write) begin
`ifdef AVS_BYTEENABLE_RMW_EN
          if (bus.avs_byteenable != '1) begin
            m_rd_s = cyc + 1; m_cap = cyc + 1 + RL; m_merge = cyc + 2 + RL;
            m_wr_s = cyc + 3 + RL; m_ack = m_wr_s + WG + 1;
          end else
`endif
          begin
            m_wr_s = cyc + 1; m_ack = cyc + 2 + WG;
          end
        end else begin
          m_rd_s = cyc + 1; m_cap = cyc + 1 + RL; m_ack = cyc + 2 + RL;
        end
      end
    end
  end

  // Present a request and hold it until acknowledged; returns the accept cycle.
  task automatic xfer(input bit rd, input bit wr, input logic [AW-3:0] a,
                      input logic [BW-1:0] d, input logic [BW/8-1:0] be, output int t);
    int n;
    bus.avs_read = rd; bus.avs_write = wr; bus.avs_address = a;
    bus.avs_writedata = d; bus.avs_byteenable = be;
    t = cyc;
    n = 0;
    do begin
      @(negedge reg_clk);
      n++;
    end while (bus.avs_waitrequest && n < 40);
    if (bus.avs_waitrequest) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no acknowledge expected one within 40 cycles");
    end
    @(posedge reg_clk); #1;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2, r0, w0, a0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_address = '0;
    bus.avs_writedata = '0; bus.avs_byteenable = '1;
    repeat (3) @(posedge reg_clk);
    #1 reset_in = 1'b0;
    @(negedge reg_clk);
    chk("post_reset_waitrequest", bus.avs_waitrequest, 1);
    chk("post_reset_readdata", bus.avs_readdata, 0);
    @(posedge reg_clk); #1;

    // Single read at 0x1100
    rd_base = 32'hA5A5_0001;
    xfer(1, 0, 14'h0440, 32'h0, 4'hF, t);
    chk("rd_strobe_latency", obs_rd_last - t, 1);
    chk("rd_ack_latency", obs_ack_last - t, 6);
    chk("rd_data", obs_ack_data, 32'hA5A5_0001);

    // Single write at 0x1104
    xfer(0, 1, 14'h0441, 32'h00FF_FFFF, 4'hF, t);
    chk("wr_strobe_latency", obs_wr_last - t, 1);
    chk("wr_ack_latency", obs_ack_last - t, 5);
    chk("wr_data", obs_wr_data, 32'h00FF_FFFF);

    // Read with a per-cycle changing source: capture is at strobe + ReadLatency
    vary = 1'b1; rd_base = 32'h3C00_0000;
    xfer(1, 0, 14'h1234, 32'h5555_AAAA, 4'hF, t);
    chk("rd_capture_cycle", obs_ack_data, 32'h3C00_0000 ^ 32'(t + 5));
    vary = 1'b0;

    // Read and write together: write only
    r0 = n_rd; w0 = n_wr; a0 = n_ack;
    xfer(1, 1, 14'h0002, 32'hCAFE_F00D, 4'hF, t);
    chk("tie_no_read", n_rd - r0, 0);
    chk("tie_one_write", n_wr - w0, 1);
    chk("tie_one_ack", n_ack - a0, 1);
    chk("tie_wr_data", obs_wr_data, 32'hCAFE_F00D);

    // Partial byteenable write
    r0 = n_rd; a0 = n_ack;
    rd_base = 32'h1111_1111;
    xfer(0, 1, 14'h0010, 32'h0000_3400, 4'b0010, t);
`ifdef AVS_BYTEENABLE_RMW_EN
    chk("rmw_merged_data", obs_wr_data, 32'h1111_3411);
    chk("rmw_one_read", n_rd - r0, 1);
    chk("rmw_one_ack", n_ack - a0, 1);
    chk("rmw_ack_latency", obs_ack_last - t, RL + WG + 4);
`else
    chk("be_ignored_data", obs_wr_data, 32'h0000_3400);
    chk("be_ignored_no_read", n_rd - r0, 0);
    chk("be_ignored_ack_latency", obs_ack_last - t, 5);
`endif

    // Reset while in RD_WAIT abandons the read
    a0 = n_ack;
    bus.avs_read = 1'b1; bus.avs_address = 14'h0333;
    repeat (3) begin @(posedge reg_clk); #1; end
    reset_in = 1'b1; bus.avs_read = 1'b0;
    #1;
    chk("midrst_waitrequest", bus.avs_waitrequest, 1);
    chk("midrst_read_reg", read_reg, 0);
    chk("midrst_busaddress", busaddress, 0);
    @(posedge reg_clk); #1 reset_in = 1'b0;
    repeat (8) begin @(posedge reg_clk); #1; end
    chk("midrst_no_ack", n_ack - a0, 0);
    rd_base = 32'h0BAD_F00D;
    xfer(1, 0, 14'h0333, 32'h0, 4'hF, t);
    chk("postrst_rd_data", obs_ack_data, 32'h0BAD_F00D);
    chk("postrst_rd_latency", obs_ack_last - t, 6);

    // Back-to-back reads: ReadLatency+2 idle cycles between strobes
    rd_base = 32'h7777_0000;
    xfer(1, 0, 14'h0100, 32'h0, 4'hF, t);
    xfer(1, 0, 14'h0101, 32'h0, 4'hF, t2);
    chk("b2b_accept_gap", t2 - t, RL + 3);
    chk("b2b_strobe_spacing", obs_rd_last - obs_rd_prev, RL + 3);

    // Back-to-back write then read with a varying source
    vary = 1'b1; rd_base = 32'h00C0_FFEE;
    xfer(0, 1, 14'h3FFF, 32'hFFFF_0000, 4'hF, t);
    xfer(1, 0, 14'h0000, 32'h1234_5678, 4'hF, t2);
    chk("wr_rd_accept_gap", t2 - t, WG + 3);
    chk("wr_rd_capture", obs_ack_data, 32'h00C0_FFEE ^ 32'(t2 + 5));
    vary = 1'b0;

    repeat (4) @(posedge reg_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
